// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared types and constants for the instruction-memory
//               loader / fetch responder of the memoryless RISC-V core.
//               - state_t     : sequencer states (IDLE, LOAD, RUN, HALT)
//               - NOP_WORD    : addi x0,x0,0, shown whenever no real fetch
//               - HALT_WORD   : fetched word that stops execution
//               - RV_OPCODE_W : width of the RV32 major opcode field
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    localparam int          RV_OPCODE_W = 7;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
    localparam logic [31:0] HALT_WORD   = 32'h0000_007f;

    typedef logic [31:0]            word_t;
    typedef logic [RV_OPCODE_W-1:0] opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    // Major opcode of an RV32 instruction word.
    function automatic opcode_t f_opcode(input word_t w);
        return w[RV_OPCODE_W-1:0];
    endfunction

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
// Module      : imem_ram
// Description : DEPTH x 32 single-port instruction RAM. Synchronous write,
//               registered (read-first) read, no reset on the array or on
//               the read register.
// Ports       : clk      - clock, rising edge
//               i_we     - write enable
//               i_addr   - word address (shared by read and write)
//               i_wdata  - write data
//               o_rdata  - read data, valid the cycle after i_addr
// Revision    : 1.0 - initial release
// ============================================================================
module imem_ram
    import imem_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  word_t         i_wdata,
    output word_t         o_rdata
);

    word_t r_mem [DEPTH];
    word_t r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule : imem_ram
`default_nettype wire

// File: rtl/imem_loader_fetch.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_fetch
// Description : Instruction-side responder for the memoryless RISC-V core.
//               A byte-serial load port fills the instruction RAM with
//               little-endian words from word 0 upward; in RUN the block
//               returns mem[pc>>2] one cycle after sampling pc, stalls the
//               core outside RUN and halts on HALT_WORD or a misaligned pc.
// Ports       : CLOCK_50      - sole clock, rising edge
//               reset_n       - synchronous active-low reset
//               pc            - core byte address
//               instr         - instruction to core (NOP_WORD when not valid)
//               instr_valid   - instr is a real fetch of last cycle's pc
//               core_stall    - core must hold pc and not commit
//               ld_en         - load-mode request (level)
//               ld_byte       - load data byte
//               ld_byte_valid - ld_byte qualifier
//               ld_count      - complete words written by current/last load
//               ld_overflow   - sticky: byte offered after RAM full
//               halted        - sequencer in HALT
//               misaligned    - sticky: RUN fetch with pc[1:0] != 0
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader_fetch #(
    parameter int          PC_W      = 11,
    parameter int          DEPTH     = 512,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013,
    parameter logic [31:0] HALT_WORD = 32'h0000_007f
) (
    input  logic            CLOCK_50,
    input  logic            reset_n,
    input  logic [PC_W-1:0] pc,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic            core_stall,
    input  logic            ld_en,
    input  logic [7:0]      ld_byte,
    input  logic            ld_byte_valid,
    output logic [9:0]      ld_count,
    output logic            ld_overflow,
    output logic            halted,
    output logic            misaligned
);

    import imem_pkg::*;

    localparam int         AW      = PC_W - 2;
    localparam logic [9:0] c_depth = 10'(DEPTH);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic        r_fetch_valid;  // RAM read register holds a real fetch
    logic        r_run_entry;    // first cycle of RUN, nothing in flight
    logic        r_misaligned;
    logic        r_ld_overflow;
    logic [9:0]  r_ld_count;     // low AW bits double as the word pointer
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_partial;      // bytes 0..2 of the word being assembled

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t        w_state_nxt;
    logic          w_fetch;
    logic          w_misfetch;
    logic          w_load_start;
    logic          w_halt_hit;
    logic          w_byte_take;
    logic          w_full;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [31:0]   w_ram_wdata;
    logic [31:0]   w_rdata;

    // The halt word is recognised while it is being presented, so the core
    // sees it valid for exactly one cycle before the sequencer leaves RUN.
    assign w_halt_hit  = r_fetch_valid && (w_rdata == HALT_WORD);

    // A byte in the same cycle ld_en rises is dropped: state is not yet LOAD.
    assign w_byte_take = (r_state == LOAD) && ld_en && ld_byte_valid;

    // Writes stop at DEPTH words, so the word pointer never wraps.
    assign w_full      = (r_ld_count == c_depth);
    assign w_ram_we    = w_byte_take && !w_full && (r_byte_cnt == 2'd3);
    assign w_ram_wdata = {ld_byte, r_partial};

    // Single port: load and fetch are exclusive by state, so the address
    // simply follows the state.
    assign w_ram_addr  = (r_state == LOAD) ? r_ld_count[AW-1:0]
                                           : pc[PC_W-1:2];

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next state and per-cycle strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_fetch      = 1'b0;
        w_misfetch   = 1'b0;
        w_load_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (ld_en) begin
                    w_state_nxt  = LOAD;
                    w_load_start = 1'b1;
                end
            end
            LOAD: begin
                if (!ld_en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // Reload request wins over halting; no fetch is issued
                // on the edge that leaves RUN.
                if (ld_en) begin
                    w_state_nxt  = LOAD;
                    w_load_start = 1'b1;
                end else if (w_halt_hit) begin
                    w_state_nxt = HALT;
                end else if (pc[1:0] != 2'b00) begin
                    w_state_nxt = HALT;
                    w_misfetch  = 1'b1;
                end else begin
                    w_fetch = 1'b1;
                end
            end
            HALT: begin
                if (ld_en) begin
                    w_state_nxt  = LOAD;
                    w_load_start = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch status, load assembler and counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_fetch_valid <= 1'b0;
            r_run_entry   <= 1'b0;
            r_misaligned  <= 1'b0;
            r_ld_overflow <= 1'b0;
            r_ld_count    <= 10'd0;
            r_byte_cnt    <= 2'd0;
            r_partial     <= 24'd0;
        end else begin
            r_fetch_valid <= w_fetch;
            r_run_entry   <= (r_state == LOAD) && (w_state_nxt == RUN);

            if (w_misfetch) begin
                r_misaligned <= 1'b1;
            end

            if (w_load_start) begin
                r_ld_count    <= 10'd0;
                r_ld_overflow <= 1'b0;
                r_byte_cnt    <= 2'd0;
                r_partial     <= 24'd0;
            end else if (w_byte_take) begin
                if (w_full) begin
                    r_ld_overflow <= 1'b1;
                end else if (r_byte_cnt == 2'd3) begin
                    r_ld_count <= r_ld_count + 10'd1;
                    r_byte_cnt <= 2'd0;
                    r_partial  <= 24'd0;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    case (r_byte_cnt)
                        2'd0:    r_partial[7:0]   <= ld_byte;
                        2'd1:    r_partial[15:8]  <= ld_byte;
                        default: r_partial[23:16] <= ld_byte;
                    endcase
                end
            end else if ((r_state == LOAD) && !ld_en) begin
                // Leaving LOAD: an incomplete word is thrown away.
                r_byte_cnt <= 2'd0;
                r_partial  <= 24'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Instruction RAM
    // ------------------------------------------------------------------
    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (CLOCK_50),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign instr       = r_fetch_valid ? w_rdata : NOP_WORD;
    assign instr_valid = r_fetch_valid;
    assign core_stall  = (r_state != RUN) || r_run_entry;
    assign halted      = (r_state == HALT);
    assign misaligned  = r_misaligned;
    assign ld_overflow = r_ld_overflow;
    assign ld_count    = r_ld_count;

endmodule : imem_loader_fetch
`default_nettype wire

// File: tb/tb_imem_loader_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader_fetch
// Description : Self-checking bench for imem_loader_fetch. Fetch results
//               are predicted into a scoreboard queue as each pc is driven
//               and compared when the registered instruction appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader_fetch;

    localparam logic [31:0] c_nop  = 32'h0000_0013;
    localparam logic [31:0] c_halt = 32'h0000_007f;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic [10:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        core_stall;
    logic        ld_en;
    logic [7:0]  ld_byte;
    logic        ld_byte_valid;
    logic [9:0]  ld_count;
    logic        ld_overflow;
    logic        halted;
    logic        misaligned;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  ld_q [$];   // bytes to stream on the next load
    logic [32:0] sb_q [$];   // {expected valid, expected instr}

    imem_loader_fetch u_dut (
        .CLOCK_50      (CLOCK_50),
        .reset_n       (reset_n),
        .pc            (pc),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .core_stall    (core_stall),
        .ld_en         (ld_en),
        .ld_byte       (ld_byte),
        .ld_byte_valid (ld_byte_valid),
        .ld_count      (ld_count),
        .ld_overflow   (ld_overflow),
        .halted        (halted),
        .misaligned    (misaligned)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            ld_q.push_back(w[8*k +: 8]);
        end
    endtask

    // Raise ld_en (optionally with a byte that must be ignored), stream ld_q,
    // then drop ld_en. Returns inside the RUN entry cycle.
    task automatic do_load(input logic first_valid, input logic [7:0] first_byte);
        ld_en         = 1'b1;
        ld_byte_valid = first_valid;
        ld_byte       = first_byte;
        tick();
        while (ld_q.size() > 0) begin
            ld_byte       = ld_q.pop_front();
            ld_byte_valid = 1'b1;
            tick();
        end
        ld_byte_valid = 1'b0;
        ld_en         = 1'b0;
        tick();
        @(negedge CLOCK_50);
    endtask

    // Drive pc, predict the response, and compare one cycle later.
    task automatic fetch(input logic [10:0] a, input logic [31:0] exp_i, input logic exp_v);
        logic [32:0] e;
        pc = a;
        sb_q.push_back({exp_v, exp_i});
        tick();
        @(negedge CLOCK_50);
        e = sb_q.pop_front();
        chk($sformatf("instr@%h", a), instr, e[31:0]);
        chk($sformatf("instr_valid@%h", a), 32'(instr_valid), 32'(e[32]));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_instr"},       instr,             c_nop);
        chk({tag, "_instr_valid"}, 32'(instr_valid),  32'd0);
        chk({tag, "_core_stall"},  32'(core_stall),   32'd1);
        chk({tag, "_ld_count"},    32'(ld_count),     32'd0);
        chk({tag, "_ld_overflow"}, 32'(ld_overflow),  32'd0);
        chk({tag, "_halted"},      32'(halted),       32'd0);
        chk({tag, "_misaligned"},  32'(misaligned),   32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        pc            = 11'd0;
        ld_en         = 1'b0;
        ld_byte       = 8'd0;
        ld_byte_valid = 1'b0;
        tick();
        tick();
        @(negedge CLOCK_50);
        chk_reset_values("rst");
        reset_n = 1'b1;

        // Program load and run to the halt word.
        push_word(32'h0050_0293);
        push_word(32'h00c0_00ef);
        push_word(32'h0090_0113);
        push_word(c_halt);
        do_load(1'b0, 8'h00);
        chk("prog_ld_count", 32'(ld_count), 32'd4);
        chk("prog_entry_stall", 32'(core_stall), 32'd1);
        fetch(11'd0, 32'h0050_0293, 1'b1);
        chk("prog_run_stall", 32'(core_stall), 32'd0);
        fetch(11'd4,  32'h00c0_00ef, 1'b1);
        fetch(11'd8,  32'h0090_0113, 1'b1);
        fetch(11'd12, c_halt,        1'b1);
        fetch(11'd16, c_nop,         1'b0);
        chk("prog_halted", 32'(halted), 32'd1);
        chk("prog_halt_stall", 32'(core_stall), 32'd1);

        // Reload from HALT: byte on the ld_en rising cycle is ignored.
        push_word(32'h1234_5678);
        do_load(1'b1, 8'hEE);
        chk("reload_ld_count", 32'(ld_count), 32'd1);
        chk("reload_halted", 32'(halted), 32'd0);
        fetch(11'd0, 32'h1234_5678, 1'b1);
        fetch(11'd4, 32'h00c0_00ef, 1'b1);

        // Partial word (entered from RUN): trailing bytes are discarded.
        push_word(32'hA1B2_C3D4);
        ld_q.push_back(8'h55);
        ld_q.push_back(8'h66);
        do_load(1'b0, 8'h00);
        chk("partial_ld_count", 32'(ld_count), 32'd1);
        fetch(11'd0, 32'hA1B2_C3D4, 1'b1);
        fetch(11'd4, 32'h00c0_00ef, 1'b1);

        // Misaligned fetch.
        fetch(11'h006, c_nop, 1'b0);
        chk("mis_misaligned", 32'(misaligned), 32'd1);
        chk("mis_halted", 32'(halted), 32'd1);
        chk("mis_stall", 32'(core_stall), 32'd1);

        // Reset in the middle of a load.
        ld_en = 1'b1;
        tick();
        push_word(32'hCAFE_0001);
        push_word(32'hCAFE_0002);
        ld_q.push_back(8'h77);
        ld_q.push_back(8'h88);
        while (ld_q.size() > 0) begin
            ld_byte       = ld_q.pop_front();
            ld_byte_valid = 1'b1;
            tick();
        end
        reset_n       = 1'b0;
        ld_byte_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        ld_en   = 1'b0;
        @(negedge CLOCK_50);
        chk_reset_values("midrst");
        do_load(1'b0, 8'h00);
        chk("midrst_ld_count", 32'(ld_count), 32'd0);
        fetch(11'd0, 32'hCAFE_0001, 1'b1);
        fetch(11'd4, 32'hCAFE_0002, 1'b1);

        // Overflow: DEPTH full words plus one extra byte (entered from RUN).
        for (int i = 0; i < 512; i++) begin
            push_word({16'hC0DE, 16'(i)});
        end
        ld_q.push_back(8'h5A);
        do_load(1'b0, 8'h00);
        chk("ovf_ld_count", 32'(ld_count), 32'd512);
        chk("ovf_ld_overflow", 32'(ld_overflow), 32'd1);
        fetch(11'd0,    32'hC0DE_0000, 1'b1);
        fetch(11'h7FC,  32'hC0DE_01FF, 1'b1);
        fetch(11'h200,  32'hC0DE_0080, 1'b1);
        chk("ovf_sticky", 32'(ld_overflow), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_imem_loader_fetch
`default_nettype wire
